// File: rtl/uart_rx_buffer_pkg.sv
// Shared receive-path types and constants for the UART receive controller
// and the receive buffer that drains it.
package uart_rx_buffer_pkg;

  typedef enum logic [1:0] {
    S_RX_IDLE,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP
  } UART_RX_state_type;

  typedef enum logic {
    S_RXB_IDLE,
    S_RXB_UNLOAD
  } RX_Buffer_state_type;

  localparam logic [7:0] FRAME_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_byte_fifo.sv
// 9-bit wide circular FIFO ({overrun, data}) with show-ahead head output,
// synchronous flush and occupancy count.
module uart_byte_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            Resetn,
  input  logic            Flush,
  input  logic            Push,
  input  logic [8:0]      Push_data,
  input  logic            Pop,
  output logic [8:0]      Head_data,
  output logic [ADDR_W:0] Count,
  output logic            Full,
  output logic            Not_empty
);

  logic [8:0]        mem_q [DEPTH];
  logic [8:0]        mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full;
  logic              push_en;
  logic              pop_en;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign push_en = Push && !full;
  assign pop_en  = Pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over a same-cycle push or pop; the pushed byte is dropped.
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = Push_data;
        wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (push_en && !pop_en) begin
        count_d = count_q + (ADDR_W+1)'(1);
      end else if (!push_en && pop_en) begin
        count_d = count_q - (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign Head_data = mem_q[rd_ptr_q];
  assign Count     = count_q;
  assign Full      = full;
  assign Not_empty = (count_q != '0);

endmodule

// File: rtl/uart_rx_buffer.sv
// Drains the UART receive controller's holding register into a FIFO and
// exposes it as a valid/ready pop port with overflow and frame-error bookkeeping.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DROP_ON_FULL = 0,
  parameter int unsigned ADDR_W       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            Resetn,
  input  logic            Enable,
  input  logic            Flush,
  input  logic            Clear_errors,
  input  logic [7:0]      RX_data,
  input  logic            Empty,
  input  logic            Overrun,
  input  logic            Frame_error,
  output logic            Unload_data,
  output logic            Pop_valid,
  input  logic            Pop_ready,
  output logic [7:0]      Pop_data,
  output logic            Pop_overrun,
  output logic [ADDR_W:0] Count,
  output logic            Full,
  output logic            Fifo_overflow,
  output logic [7:0]      Frame_error_count
);

  localparam logic DROP_EN = (DROP_ON_FULL != 0);

  RX_Buffer_state_type state_q, state_d;
  logic       unload_q, unload_d;
  logic       overflow_q, overflow_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] fe_cnt_q, fe_cnt_d;
  logic       push;
  logic       drop;
  logic       fifo_full;
  logic       fifo_not_empty;
  logic [8:0] head;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .Resetn    (Resetn),
    .Flush     (Flush),
    .Push      (push),
    .Push_data ({Overrun, RX_data}),
    .Pop       (Pop_ready && fifo_not_empty),
    .Head_data (head),
    .Count     (Count),
    .Full      (fifo_full),
    .Not_empty (fifo_not_empty)
  );

  // UNLOAD lasts one cycle so IDLE always samples Empty after the controller reacts.
  always_comb begin
    state_d  = state_q;
    unload_d = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      S_RXB_IDLE: begin
        if (Enable && !Empty && (!fifo_full || DROP_EN)) begin
          push     = !fifo_full;
          drop     = fifo_full;
          unload_d = 1'b1;
          state_d  = S_RXB_UNLOAD;
        end
      end
      S_RXB_UNLOAD: state_d = S_RXB_IDLE;
      default:      state_d = S_RXB_IDLE;
    endcase
  end

  always_comb begin
    frame_err_d = Frame_error;
    overflow_d  = overflow_q | drop;
    fe_cnt_d    = fe_cnt_q;
    if (Frame_error && !frame_err_q && (fe_cnt_q != FRAME_CNT_MAX)) begin
      fe_cnt_d = fe_cnt_q + 8'd1;
    end
    if (Clear_errors) begin
      overflow_d = 1'b0;
      fe_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q     <= S_RXB_IDLE;
      unload_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      fe_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      unload_q    <= unload_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      fe_cnt_q    <= fe_cnt_d;
    end
  end

  assign Unload_data       = unload_q;
  assign Pop_valid         = fifo_not_empty;
  assign Pop_data          = head[7:0];
  assign Pop_overrun       = head[8];
  assign Full              = fifo_full;
  assign Fifo_overflow     = overflow_q;
  assign Frame_error_count = fe_cnt_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: a behavioural receive controller feeds
// the back-pressure instance; a second instance exercises drop-on-full.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       Enable = 1'b1;
  logic       Flush = 1'b0;
  logic       Frame_error = 1'b0;

  logic       Clear0 = 1'b0;
  logic [7:0] RX_data0 = 8'h00;
  logic       Empty0 = 1'b1;
  logic       Overrun0 = 1'b0;
  logic       Pop_ready0 = 1'b0;
  logic       Unload_data0, Pop_valid0, Pop_overrun0, Full0, Fifo_overflow0;
  logic [7:0] Pop_data0, Frame_error_count0;
  logic [4:0] Count0;

  logic       Clear1 = 1'b0;
  logic [7:0] RX_data1 = 8'h00;
  logic       Empty1 = 1'b1;
  logic       Unload_data1, Pop_valid1, Pop_overrun1, Full1, Fifo_overflow1;
  logic [7:0] Pop_data1, Frame_error_count1;
  logic [4:0] Count1;

  always #5 clk = ~clk;

  uart_rx_buffer #(.DEPTH(16), .DROP_ON_FULL(0)) dut0 (
    .clk(clk), .Resetn(Resetn), .Enable(Enable), .Flush(Flush),
    .Clear_errors(Clear0), .RX_data(RX_data0), .Empty(Empty0),
    .Overrun(Overrun0), .Frame_error(Frame_error), .Unload_data(Unload_data0),
    .Pop_valid(Pop_valid0), .Pop_ready(Pop_ready0), .Pop_data(Pop_data0),
    .Pop_overrun(Pop_overrun0), .Count(Count0), .Full(Full0),
    .Fifo_overflow(Fifo_overflow0), .Frame_error_count(Frame_error_count0)
  );

  uart_rx_buffer #(.DEPTH(16), .DROP_ON_FULL(1)) dut1 (
    .clk(clk), .Resetn(Resetn), .Enable(Enable), .Flush(Flush),
    .Clear_errors(Clear1), .RX_data(RX_data1), .Empty(Empty1),
    .Overrun(1'b0), .Frame_error(Frame_error), .Unload_data(Unload_data1),
    .Pop_valid(Pop_valid1), .Pop_ready(1'b0), .Pop_data(Pop_data1),
    .Pop_overrun(Pop_overrun1), .Count(Count1), .Full(Full1),
    .Fifo_overflow(Fifo_overflow1), .Frame_error_count(Frame_error_count1)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned unl_cnt  = 0;
  logic [8:0]  src_q [$];
  logic [8:0]  exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Controller model: on a sampled Unload_data it hands over its byte and
  // either reloads on the same edge or goes empty; it ignores Unload in reset.
  task automatic ctrl_react();
    if (Unload_data0 && Resetn) begin
      unl_cnt++;
      exp_q.push_back({Overrun0, RX_data0});
      if (src_q.size() > 0) {Overrun0, RX_data0} = src_q.pop_front();
      else Empty0 = 1'b1;
    end else if (Empty0 && src_q.size() > 0) begin
      {Overrun0, RX_data0} = src_q.pop_front();
      Empty0 = 1'b0;
    end
  endtask

  // Inputs are final here; the pop that fires at the next edge is scored now.
  task automatic step();
    logic [8:0] e;
    ctrl_react();
    if (Pop_valid0 && Pop_ready0 && !Flush && Resetn) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("pop_head", 32'({Pop_overrun0, Pop_data0}), 32'(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic pop_one();
    Pop_ready0 = 1'b1;
    step();
    Pop_ready0 = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (32'(Count0) != target && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(Count0), target);
  endtask

  initial begin
    int unsigned u0;
    logic        got;

    @(negedge clk);
    step();
    check_eq("rst_unload", 32'(Unload_data0), 0);
    check_eq("rst_count", 32'(Count0), 0);
    check_eq("rst_valid", 32'(Pop_valid0), 0);
    check_eq("rst_full", 32'(Full0), 0);
    check_eq("rst_ovf", 32'(Fifo_overflow0), 0);
    check_eq("rst_fec", 32'(Frame_error_count0), 0);
    check_eq("rst_head", 32'({Pop_overrun0, Pop_data0}), 0);
    Resetn = 1'b1;
    step();

    // Single byte: Unload one cycle after Empty falls, lasting one cycle.
    src_q.push_back(9'h0A5);
    step();
    check_eq("single_unload_hi", 32'(Unload_data0), 1);
    step();
    check_eq("single_unload_lo", 32'(Unload_data0), 0);
    check_eq("single_valid", 32'(Pop_valid0), 1);
    check_eq("single_data", 32'(Pop_data0), 32'h A5);
    check_eq("single_count", 32'(Count0), 1);
    pop_one();
    check_eq("single_count0", 32'(Count0), 0);

    // Capture disabled while Enable is low.
    Enable = 1'b0;
    src_q.push_back(9'h077);
    repeat (4) step();
    check_eq("en_off_count", 32'(Count0), 0);
    Enable = 1'b1;
    wait_count("en_on_count", 1, 10);
    step();
    pop_one();

    // Fill to DEPTH, then back-pressure the 17th byte.
    for (int i = 0; i <= 16; i++) src_q.push_back(9'(i));
    wait_count("fill16", 16, 80);
    step();
    u0 = unl_cnt;
    repeat (4) step();
    check_eq("full_no_unload", unl_cnt, u0);
    check_eq("full_flag", 32'(Full0), 1);
    check_eq("full_count", 32'(Count0), 16);
    check_eq("full_no_ovf", 32'(Fifo_overflow0), 0);
    pop_one();
    wait_count("refill16", 16, 6);
    step();
    for (int i = 0; i < 16; i++) pop_one();
    check_eq("drain_count", 32'(Count0), 0);
    check_eq("drain_valid", 32'(Pop_valid0), 0);
    check_eq("drain_sb", 32'(exp_q.size()), 0);

    // Same-edge reload: 3C presented as 3B is unloaded, tagged with Overrun.
    u0 = unl_cnt;
    src_q.push_back(9'h03B);
    src_q.push_back(9'h13C);
    wait_count("b2b_count", 2, 12);
    step();
    pop_one();
    pop_one();
    check_eq("b2b_unloads", unl_cnt - u0, 2);
    check_eq("b2b_count0", 32'(Count0), 0);

    // Frame errors: count, saturate, clear priority.
    for (int i = 0; i < 300; i++) begin
      Frame_error = 1'b1;
      step();
      Frame_error = 1'b0;
      step();
      if (i == 9) check_eq("fec_10", 32'(Frame_error_count0), 10);
    end
    check_eq("fec_sat", 32'(Frame_error_count0), 255);
    Frame_error = 1'b1;
    Clear0 = 1'b1;
    step();
    Clear0 = 1'b0;
    Frame_error = 1'b0;
    step();
    check_eq("fec_clear_prio", 32'(Frame_error_count0), 0);

    // Flush with Count=5 while a push and a pop land in the same cycle.
    for (int i = 0; i < 5; i++) src_q.push_back(9'(8'h50 + i));
    wait_count("flush_pre", 5, 30);
    step();
    src_q.push_back(9'h0F5);
    Flush = 1'b1;
    Pop_ready0 = 1'b1;
    step();
    Flush = 1'b0;
    Pop_ready0 = 1'b0;
    check_eq("flush_count", 32'(Count0), 0);
    check_eq("flush_valid", 32'(Pop_valid0), 0);
    step();
    exp_q.delete();
    step();
    check_eq("flush_lost", 32'(Count0), 0);

    // Reset during UNLOAD with Count=3; held byte recaptured afterwards.
    src_q.push_back(9'h061);
    src_q.push_back(9'h062);
    wait_count("rst_pre", 2, 12);
    step();
    src_q.push_back(9'h1C7);
    step();
    check_eq("rst_mid_unload", 32'(Unload_data0), 1);
    check_eq("rst_mid_count", 32'(Count0), 3);
    Resetn = 1'b0;
    step();
    check_eq("rst2_unload", 32'(Unload_data0), 0);
    check_eq("rst2_count", 32'(Count0), 0);
    check_eq("rst2_valid", 32'(Pop_valid0), 0);
    check_eq("rst2_head", 32'({Pop_overrun0, Pop_data0}), 0);
    exp_q.delete();
    Resetn = 1'b1;
    wait_count("recapture", 1, 10);
    step();
    pop_one();
    check_eq("recap_sb", 32'(exp_q.size()), 0);

    // Drop-on-full instance: 16 fills, then 8'hEE is unloaded and discarded.
    for (int i = 0; i < 17; i++) begin
      RX_data1 = (i == 16) ? 8'hEE : 8'(i);
      Empty1 = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        if (Unload_data1) got = 1'b1;
      end
      Empty1 = 1'b1;
      if (i == 15) check_eq("drop_pre_ovf", 32'(Fifo_overflow1), 0);
      if (i == 16) check_eq("drop_unload", 32'(got), 1);
      step();
    end
    check_eq("drop_ovf", 32'(Fifo_overflow1), 1);
    check_eq("drop_count", 32'(Count1), 16);
    check_eq("drop_head", 32'(Pop_data1), 0);
    Clear1 = 1'b1;
    step();
    Clear1 = 1'b0;
    check_eq("drop_ovf_clear", 32'(Fifo_overflow1), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Sits directly downstream of the UART receive controller.
- Drains each received byte from the controller's single-byte holding register (RX_data/Empty/Unload_data handshake) into a DEPTH-entry circular FIFO.
- Exposes the FIFO to the AXI-lite register side through a valid/ready pop port.
- Tags each byte with the controller's Overrun flag, and keeps a sticky FIFO-overflow flag and a saturating frame-error counter.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- DROP_ON_FULL, 0, 0 = leave the byte in the controller when the FIFO is full (back-pressure); 1 = unload and discard it.
- ADDR_W, $clog2(DEPTH), derived pointer width; not overridden.

Ports:
- clk  in  1  system clock
- Resetn  in  1  synchronous active-low reset
- Enable  in  1  capture enable; when low, no new bytes are unloaded
- Flush  in  1  one-cycle pulse that empties the FIFO
- Clear_errors  in  1  clears Fifo_overflow and Frame_error_count
- RX_data  in  8  byte from receive controller
- Empty  in  1  controller holding register empty (registered in controller)
- Overrun  in  1  controller overrun flag, valid while Empty=0
- Frame_error  in  1  controller frame-error level
- Unload_data  out  1  registered one-cycle pulse to the controller
- Pop_valid  out  1  FIFO non-empty
- Pop_ready  in  1  consumer accepts the head entry
- Pop_data  out  8  head byte (show-ahead)
- Pop_overrun  out  1  Overrun tag of the head byte
- Count  out  ADDR_W+1  occupancy
- Full  out  1  Count==DEPTH
- Fifo_overflow  out  1  sticky: a byte was discarded (DROP_ON_FULL=1 only)
- Frame_error_count  out  8  saturating count of Frame_error rising edges

Behaviour:
- Reset is synchronous, active-low, on posedge clk. Reset values:
  - Unload_data=0, Count=0, Pop_valid=0, Full=0
  - Fifo_overflow=0, Frame_error_count=0
  - Pop_data=0, Pop_overrun=0, pointers=0, FSM=S_RXB_IDLE
- Reset mid-handshake abandons the transfer. The controller keeps its byte, which is recaptured after reset.
- FSM S_RXB_IDLE:
  - Captures when Enable && !Empty && (!Full || DROP_ON_FULL).
  - When !Full: writes {Overrun, RX_data} at wr_ptr.
  - When Full with DROP_ON_FULL=1: discards the byte and sets Fifo_overflow.
  - Any capture registers Unload_data=1 and moves to S_RXB_UNLOAD.
- FSM S_RXB_UNLOAD:
  - Unload_data=1 for exactly this cycle; the controller sets Empty at this edge.
  - Returns to IDLE with Unload_data=0; IDLE therefore always samples the updated Empty.
  - Minimum two cycles per byte.
- If the controller loads a new byte on the same edge it sees Unload_data, its Empty=0 takes priority. IDLE then captures that new byte normally, with no loss and no double-capture.
- Full with DROP_ON_FULL=0: no capture and no Unload_data. The controller flags Overrun on the next byte; that tag is propagated when the byte is finally captured.
- Pop: fires when Pop_valid && Pop_ready; rd_ptr increments.
- Push and pop in the same cycle: Count is unchanged. Push eligibility uses the registered Full, so a full FIFO does not accept a push even while popping.
- Pointers wrap modulo DEPTH. Count = pushes − pops, in 0..DEPTH.
- Flush has priority over push and pop in the same cycle:
  - pointers and Count go to 0;
  - an in-flight Unload_data pulse still completes;
  - a byte captured in that cycle is lost.
- Frame_error_count:
  - A registered copy of Frame_error detects the rising edge; each edge increments the count, saturating at 255.
  - Clear_errors takes priority over a simultaneous increment or overflow set.
- Enable falling during S_RXB_UNLOAD: the pulse completes; afterwards there are no captures.
- Pop_data/Pop_overrun are read combinationally from the register array at rd_ptr. When Count=0 they hold the last head value.

Decomposition:
- Add RX_Buffer_state_type {S_RXB_IDLE, S_RXB_UNLOAD} to the shared state-type definitions alongside the receive controller's state enum.
- FRAME_CNT_MAX=8'hFF is a shared constant.
- One sub-module, uart_byte_fifo: 9-bit-wide, DEPTH-entry circular FIFO with push, pop, flush, count and full.
- The unload FSM and error bookkeeping stay in uart_rx_buffer.

Test Plan:
- Single byte: controller model presents RX_data=8'hA5, Empty=0 → Unload_data high exactly one cycle, one cycle later; then Pop_valid=1, Pop_data=8'hA5, Count=1; Pop_ready → Count=0.
- Fill DEPTH=16 with 8'h00..8'h0F, DROP_ON_FULL=0, then present 8'h10 → Full=1, no Unload_data, Empty stays 0; one pop → 8'h10 captured, Count=16, pops return 8'h01..8'h10 in order.
- DROP_ON_FULL=1, full FIFO, present 8'hEE → Unload_data pulses, Fifo_overflow=1, Count stays 16; Clear_errors → Fifo_overflow=0.
- Back-to-back: controller reloads Empty=0 with 8'h3C on the same edge as the Unload_data for 8'h3B → both captured once, in order; 8'h3C has Pop_overrun=1 when its Overrun input=1.
- Frame errors: 300 Frame_error rising edges → Frame_error_count=255; Flush with Count=5 and simultaneous push/pop → Count=0, Pop_valid=0.
- Reset (Resetn=0) asserted during S_RXB_UNLOAD with Count=3 → next cycle all outputs at reset values; the held controller byte is recaptured after release.
